gate_sweep_checker: RTL and testbench

Self-checking exhaustive sweeper for an N-input combinational gate under test. On `start` it drives every input vector 0 to 2^N-1 onto the gate and samples the gate output after a configurable settle time. It compares each sample against a mode-selected reference function and reports the pass/fail result, the error count and the first failing vector. It sits beside any gate-level block (NAND/NOR/AND/OR/XOR/XNOR) as a synthesizable, parametrised built-in exhaustive tester for that block.

---
 rtl/gate_sweep_checker.sv | 134 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive input sweeper and checker for an N-input gate
module gate_sweep_checker #(
    parameter int N      = 3,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   mode,
    output logic [N-1:0] dut_in,
    input  logic         dut_y,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         first_fail_valid,
    output logic [N-1:0] first_fail_vec
);

    localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(SETTLE - 1);
    localparam logic [N-1:0]  VEC_LAST    = {N{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state, w_state_nx;
    logic [2:0]    r_mode, w_mode_nx;
    logic          r_mode_ok, w_mode_ok_nx;
    logic [N-1:0]  r_vec, w_vec_nx;
    logic [HW-1:0] r_hold, w_hold_nx;
    logic [N:0]    r_err, w_err_nx;
    logic          r_ffv, w_ffv_nx;
    logic [N-1:0]  r_ffvec, w_ffvec_nx;
    logic          w_ref;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mode    <= 3'd0;
            r_mode_ok <= 1'b0;
            r_vec     <= '0;
            r_hold    <= '0;
            r_err     <= '0;
            r_ffv     <= 1'b0;
            r_ffvec   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_mode    <= w_mode_nx;
            r_mode_ok <= w_mode_ok_nx;
            r_vec     <= w_vec_nx;
            r_hold    <= w_hold_nx;
            r_err     <= w_err_nx;
            r_ffv     <= w_ffv_nx;
            r_ffvec   <= w_ffvec_nx;
        end
    end

    always_comb begin
        w_ref = 1'b0;
        case (r_mode)
            3'd0:    w_ref = ~&r_vec;
            3'd1:    w_ref = ~|r_vec;
            3'd2:    w_ref = &r_vec;
            3'd3:    w_ref = |r_vec;
            3'd4:    w_ref = ^r_vec;
            3'd5:    w_ref = ~^r_vec;
            default: w_ref = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx   = r_state;
        w_mode_nx    = r_mode;
        w_mode_ok_nx = r_mode_ok;
        w_vec_nx     = r_vec;
        w_hold_nx    = r_hold;
        w_err_nx     = r_err;
        w_ffv_nx     = r_ffv;
        w_ffvec_nx   = r_ffvec;
        case (r_state)
            IDLE, DONE: begin
                // Reserved modes skip the sweep and report a failed, empty run.
                if (start) begin
                    w_vec_nx   = '0;
                    w_hold_nx  = HOLD_RELOAD;
                    w_err_nx   = '0;
                    w_ffv_nx   = 1'b0;
                    w_ffvec_nx = '0;
                    w_mode_nx  = mode;
                    if (mode <= 3'd5) begin
                        w_state_nx   = WAIT;
                        w_mode_ok_nx = 1'b1;
                    end else begin
                        w_state_nx   = DONE;
                        w_mode_ok_nx = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (r_hold != '0) begin
                    w_hold_nx = r_hold - 1'b1;
                end else begin
                    if (dut_y != w_ref) begin
                        w_err_nx = r_err + 1'b1;
                        if (!r_ffv) begin
                            w_ffv_nx   = 1'b1;
                            w_ffvec_nx = r_vec;
                        end
                    end
                    if (r_vec == VEC_LAST) begin
                        w_state_nx = DONE;
                    end else begin
                        w_vec_nx  = r_vec + 1'b1;
                        w_hold_nx = HOLD_RELOAD;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign busy             = (r_state == WAIT);
    assign done             = (r_state == DONE);
    assign dut_in           = busy ? r_vec : '0;
    assign pass             = done && (r_err == '0) && r_mode_ok;
    assign err_count        = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - directed bench for gate_sweep_checker with a NAND3 gate
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [2:0] dut_in;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic       first_fail_valid;
    logic [2:0] first_fail_vec;
    logic       stuck;

    int n_checks = 0;
    int n_fail   = 0;

    gate_sweep_checker #(.N(3), .SETTLE(2)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode             (mode),
        .dut_in           (dut_in),
        .dut_y            (dut_y),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec)
    );

    always #5 clk = ~clk;

    assign dut_y = stuck ? 1'b1 : ~&dut_in;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [2:0] m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sweep(input logic [2:0] m, input bit chk_steps, input int pulse_at);
        int cyc;
        do_start(m);
        cyc = 0;
        chk("busy_after_start", 32'(busy), 1);
        chk("done_after_start", 32'(done), 0);
        while (!done && cyc < 100) begin
            if (chk_steps) chk("dut_in_step", 32'(dut_in), cyc / 2);
            if (cyc == pulse_at) begin
                start = 1'b1;
                mode  = 3'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk("latency", cyc, 16);
        chk("busy_at_done", 32'(busy), 0);
        chk("dut_in_at_done", 32'(dut_in), 0);
    endtask

    task automatic chk_results(input int p, input int e, input int fv, input int fvec);
        chk("pass", 32'(pass), p);
        chk("err_count", 32'(err_count), e);
        chk("first_fail_valid", 32'(first_fail_valid), fv);
        chk("first_fail_vec", 32'(first_fail_vec), fvec);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 3'd0;
        stuck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dut_in", 32'(dut_in), 0);
        chk_results(0, 0, 0, 0);
        rst = 1'b0;

        // NAND reference against NAND gate: clean pass, vectors stepped every 2 cycles
        sweep(3'd0, 1'b1, -1);
        chk_results(1, 0, 0, 0);
        // NOR reference: disagrees on 001..110
        sweep(3'd1, 1'b0, -1);
        chk_results(0, 6, 1, 1);
        // AND reference: complement everywhere
        sweep(3'd2, 1'b0, -1);
        chk_results(0, 8, 1, 0);

        stuck = 1'b1;
        sweep(3'd0, 1'b0, -1);
        chk_results(0, 1, 1, 7);
        stuck = 1'b0;

        // Start pulse (with a different mode) while busy must be ignored
        sweep(3'd0, 1'b0, 5);
        chk_results(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", 32'(done), 1);
        chk("pass_held", 32'(pass), 1);

        // Restart from DONE after a failing sweep
        sweep(3'd1, 1'b0, -1);
        chk_results(0, 6, 1, 1);
        sweep(3'd0, 1'b0, -1);
        chk_results(1, 0, 0, 0);

        // Reset mid-sweep on edge T0+7
        stuck = 1'b1;
        do_start(3'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_mid", 32'(busy), 1);
        chk("dut_in_mid", 32'(dut_in), 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_dut_in", 32'(dut_in), 0);
        chk_results(0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_stays", 32'(busy), 0);
        stuck = 1'b0;

        // Reserved mode: done one edge after start, nothing driven
        do_start(3'd6);
        chk("rsv_done", 32'(done), 1);
        chk("rsv_busy", 32'(busy), 0);
        chk("rsv_dut_in", 32'(dut_in), 0);
        chk_results(0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("rsv_dut_in_hold", 32'(dut_in), 0);
        chk("rsv_done_hold", 32'(done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
